// File: rtl/alu_mem_datapath_pkg.sv
// alu_mem_datapath_pkg
//   Shared constants for the execution datapath: the data width and the
//   5-bit ALU opcode encodings used by the sequencer and alu_core.
package alu_mem_datapath_pkg;

   localparam int DATA_W = 32;
   localparam int OPC_W  = 5;

   // ALU opcode encodings; 15..31 are unused and yield zero.
   localparam logic [OPC_W-1:0] ALU_ADD   = 5'd0;
   localparam logic [OPC_W-1:0] ALU_SUB   = 5'd1;
   localparam logic [OPC_W-1:0] ALU_ADDU  = 5'd2;
   localparam logic [OPC_W-1:0] ALU_SUBU  = 5'd3;
   localparam logic [OPC_W-1:0] ALU_AND   = 5'd4;
   localparam logic [OPC_W-1:0] ALU_OR    = 5'd5;
   localparam logic [OPC_W-1:0] ALU_SLL   = 5'd6;
   localparam logic [OPC_W-1:0] ALU_SRL   = 5'd7;
   localparam logic [OPC_W-1:0] ALU_JR    = 5'd8;
   localparam logic [OPC_W-1:0] ALU_SLT   = 5'd9;
   localparam logic [OPC_W-1:0] ALU_ADDI  = 5'd10;
   localparam logic [OPC_W-1:0] ALU_ADDIU = 5'd11;
   localparam logic [OPC_W-1:0] ALU_ANDI  = 5'd12;
   localparam logic [OPC_W-1:0] ALU_ORI   = 5'd13;
   localparam logic [OPC_W-1:0] ALU_SLTI  = 5'd14;

   // Sign-extend a 16-bit immediate to the datapath width.
   function automatic logic [DATA_W-1:0] sext16(input logic [15:0] imm);
      return {{(DATA_W-16){imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/alu_mem_datapath_alu_core.sv
// alu_core
//   Purely combinational 32-bit ALU. Arithmetic wraps modulo 2^32; signed
//   and unsigned variants give identical results (no traps, no flags).
// Ports:
//   inp1 - operand A (rs value)
//   inp2 - operand B (rt value, shift amount in [4:0], immediate in [15:0])
//   opc  - operation select
//   out  - result
module alu_core
   import alu_mem_datapath_pkg::*;
(
   input  logic [DATA_W-1:0] inp1,
   input  logic [DATA_W-1:0] inp2,
   input  logic [OPC_W-1:0]  opc,
   output logic [DATA_W-1:0] out
);

   logic [DATA_W-1:0] simm;
   logic [DATA_W-1:0] zimm;
   logic [4:0]        shamt;
   logic              lt_reg_op;
   logic              lt_imm_op;

   assign simm      = sext16(inp2[15:0]);
   assign zimm      = {{(DATA_W-16){1'b0}}, inp2[15:0]};
   assign shamt     = inp2[4:0];
   assign lt_reg_op = $signed(inp1) < $signed(inp2);
   assign lt_imm_op = $signed(inp1) < $signed(simm);

   always_comb begin
      out = '0;
      case (opc)
         ALU_ADD,
         ALU_ADDU:  out = inp1 + inp2;
         ALU_SUB,
         ALU_SUBU:  out = inp1 - inp2;
         ALU_AND:   out = inp1 & inp2;
         ALU_OR:    out = inp1 | inp2;
         ALU_SLL:   out = inp1 << shamt;
         ALU_SRL:   out = inp1 >> shamt;
         ALU_JR:    out = inp1;
         ALU_SLT:   out = {{(DATA_W-1){1'b0}}, lt_reg_op};
         ALU_ADDI,
         ALU_ADDIU: out = inp1 + simm;
         ALU_ANDI:  out = inp1 & zimm;
         ALU_ORI:   out = inp1 | zimm;
         ALU_SLTI:  out = {{(DATA_W-1){1'b0}}, lt_imm_op};
         default:   out = '0;
      endcase
   end

endmodule

// File: rtl/alu_mem_datapath_dp_ram.sv
// dp_ram
//   2^W x 32 word-addressed memory: one synchronous write port, one
//   asynchronous read port. Synchronous reset clears every word and wins
//   over a simultaneous write. Reads are not bypassed: a same-address write
//   becomes visible only after the edge.
// Ports:
//   clk         - clock
//   reset       - synchronous active-high clear of all words
//   writeEnable - write strobe
//   addressa    - write address
//   datain      - write data
//   addressb    - read address
//   dataout     - read data, combinational from addressb
module dp_ram
   import alu_mem_datapath_pkg::*;
#(
   parameter int W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              writeEnable,
   input  logic [W-1:0]      addressa,
   input  logic [DATA_W-1:0] datain,
   input  logic [W-1:0]      addressb,
   output logic [DATA_W-1:0] dataout
);

   localparam int DEPTH = 2 ** W;

   logic [DATA_W-1:0] mem_reg [DEPTH];

   // The whole-array clear keeps this in registers rather than block RAM;
   // both depths used by the sequencer are small.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (writeEnable) begin
         mem_reg[addressa] <= datain;
      end
   end

   assign dataout = mem_reg[addressb];

endmodule

// File: rtl/alu_mem_datapath.sv
// alu_mem_datapath
//   Execution-side datapath: a combinational ALU alongside a 2^W x 32
//   memory (sync write, async read). Structural wrapper only; used with
//   W=8 as instruction memory and W=5 as data memory.
// Ports:
//   clk, reset           - clock and synchronous active-high memory clear
//   writeEnable, addressa, datain - memory write port
//   addressb, dataout    - memory asynchronous read port
//   inp1, inp2, opc, out - ALU operands, opcode and result
module alu_mem_datapath
   import alu_mem_datapath_pkg::*;
#(
   parameter int W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              writeEnable,
   input  logic [W-1:0]      addressa,
   input  logic [DATA_W-1:0] datain,
   input  logic [W-1:0]      addressb,
   output logic [DATA_W-1:0] dataout,
   input  logic [DATA_W-1:0] inp1,
   input  logic [DATA_W-1:0] inp2,
   input  logic [OPC_W-1:0]  opc,
   output logic [DATA_W-1:0] out
);

   dp_ram #(
      .W(W)
   ) u_ram (
      .clk        (clk),
      .reset      (reset),
      .writeEnable(writeEnable),
      .addressa   (addressa),
      .datain     (datain),
      .addressb   (addressb),
      .dataout    (dataout)
   );

   alu_core u_alu (
      .inp1(inp1),
      .inp2(inp2),
      .opc (opc),
      .out (out)
   );

endmodule

// File: tb/tb_alu_mem_datapath.sv
module tb_alu_mem_datapath;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] inp1, inp2;
   logic [4:0]  opc;
   logic [31:0] out8, out5;

   logic        we8, we5;
   logic [7:0]  adra8, adrb8;
   logic [4:0]  adra5, adrb5;
   logic [31:0] din8, din5, dout8, dout5;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_mem_datapath #(.W(8)) dut8 (
      .clk(clk), .reset(reset), .writeEnable(we8), .addressa(adra8),
      .datain(din8), .addressb(adrb8), .dataout(dout8),
      .inp1(inp1), .inp2(inp2), .opc(opc), .out(out8)
   );

   alu_mem_datapath #(.W(5)) dut5 (
      .clk(clk), .reset(reset), .writeEnable(we5), .addressa(adra5),
      .datain(din5), .addressb(adrb5), .dataout(dout5),
      .inp1(inp1), .inp2(inp2), .opc(opc), .out(out5)
   );

   typedef struct {
      string       name;
      logic [4:0]  opc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[15];

   // Reference memories (all words known after the reset that starts each phase)
   logic [31:0] model8 [256];
   logic [31:0] model5 [32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference ALU written straight from the operation table.
   function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
      int signed   sa, sb, simm;
      longint      sum;
      logic [31:0] zimm;
      sa   = int'(a);
      sb   = int'(b);
      simm = int'(shortint'(b[15:0]));
      zimm = 32'(b[15:0]);
      sum  = 0;
      case (op)
         0, 2:   begin sum = longint'(a) + longint'(b); return sum[31:0]; end
         1, 3:   begin sum = longint'(a) - longint'(b); return sum[31:0]; end
         4:      return a & b;
         5:      return a | b;
         6:      return 32'(longint'(a) * (longint'(1) << b[4:0]));
         7:      return 32'(longint'(a) / (longint'(1) << b[4:0]));
         8:      return a;
         9:      return (sa < sb) ? 32'd1 : 32'd0;
         10, 11: begin sum = longint'(a) + longint'(simm); return sum[31:0]; end
         12:     return a & zimm;
         13:     return a | zimm;
         14:     return (sa < simm) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   initial begin
      vecs[0]  = '{"add 5+-1",      5'd0,  32'd5,        32'hFFFFFFFF, 32'd4};
      vecs[1]  = '{"sub 5-1",       5'd1,  32'd5,        32'd1,        32'd4};
      vecs[2]  = '{"sub 0-1",       5'd1,  32'd0,        32'd1,        32'hFFFFFFFF};
      vecs[3]  = '{"addi wrap",     5'd10, 32'hFFFFFFFF, 32'd1,        32'd0};
      vecs[4]  = '{"addi sext",     5'd10, 32'd3,        32'h0000FFFF, 32'd2};
      vecs[5]  = '{"and",           5'd4,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000};
      vecs[6]  = '{"ori zext",      5'd13, 32'd0,        32'hFFFF8000, 32'h00008000};
      vecs[7]  = '{"sll 3<<2",      5'd6,  32'd3,        32'd2,        32'd12};
      vecs[8]  = '{"srl msb>>31",   5'd7,  32'h80000000, 32'd31,       32'd1};
      vecs[9]  = '{"slt -1<1",      5'd9,  32'hFFFFFFFF, 32'd1,        32'd1};
      vecs[10] = '{"slt 1<-1",      5'd9,  32'd1,        32'hFFFFFFFF, 32'd0};
      vecs[11] = '{"slti 2<-1",     5'd14, 32'd2,        32'h0000FFFF, 32'd0};
      vecs[12] = '{"jr pass",       5'd8,  32'd7,        32'h12345678, 32'd7};
      vecs[13] = '{"opc20 zero",    5'd20, 32'hDEADBEEF, 32'h12345678, 32'd0};
      vecs[14] = '{"andi zext",     5'd12, 32'hFFFFFFFF, 32'hFFFF1234, 32'h00001234};

      reset = 1'b0; we8 = 1'b0; we5 = 1'b0;
      adra8 = '0; adrb8 = '0; din8 = '0;
      adra5 = '0; adrb5 = '0; din5 = '0;
      inp1 = '0; inp2 = '0; opc = '0;

      // ---- Reset then read, write visible only after the edge (W=8)
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      adrb8 = 8'd3;
      #1 chk("reset read addr3", dout8, 32'd0);
      adra8 = 8'd0; din8 = 32'd5; we8 = 1'b1; adrb8 = 8'd0;
      #1 chk("addr0 before edge", dout8, 32'd0);
      tick();
      we8 = 1'b0;
      #1 chk("addr0 after edge", dout8, 32'd5);

      // ---- Write sequence at W=5
      for (int i = 0; i < 5; i++) begin
         logic [31:0] vals [5];
         vals = '{32'd5, 32'd4, 32'd2, 32'd1, 32'd3};
         adra5 = 5'(i * 4); din5 = vals[i]; we5 = 1'b1;
         tick();
      end
      we5 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         logic [31:0] vals [5];
         vals = '{32'd5, 32'd4, 32'd2, 32'd1, 32'd3};
         adrb5 = 5'(i * 4);
         #1 chk($sformatf("w5 readback a%0d", i * 4), dout5, vals[i]);
      end
      adra5 = 5'd4; din5 = 32'd99; we5 = 1'b0; adrb5 = 5'd4;
      tick();
      chk("w5 we=0 holds", dout5, 32'd4);
      we5 = 1'b1; din5 = 32'd77; reset = 1'b1;
      tick();
      reset = 1'b0; we5 = 1'b0;
      #1 chk("w5 reset beats write", dout5, 32'd0);
      adrb5 = 5'd16;
      #1 chk("w5 reset clears a16", dout5, 32'd0);

      // ---- W=8 instruction words at 21 and 255, then read-during-write
      we8 = 1'b1; adra8 = 8'd21; din8 = 32'h2002000A;
      tick();
      adra8 = 8'd255; din8 = 32'hAC220004;
      tick();
      we8 = 1'b0;
      adrb8 = 8'd21;
      #1 chk("w8 addr21", dout8, 32'h2002000A);
      adrb8 = 8'd255;
      #1 chk("w8 addr255", dout8, 32'hAC220004);
      we8 = 1'b1; adra8 = 8'd21; adrb8 = 8'd21; din8 = 32'h0BADF00D;
      #1 chk("w8 rdw old", dout8, 32'h2002000A);
      tick();
      we8 = 1'b0;
      #1 chk("w8 rdw new", dout8, 32'h0BADF00D);

      // ---- ALU directed table
      for (int i = 0; i < 15; i++) begin
         opc = vecs[i].opc; inp1 = vecs[i].a; inp2 = vecs[i].b;
         #1;
         chk({"alu ", vecs[i].name}, out8, vecs[i].exp);
      end
      opc = 5'd1; inp1 = 32'd10; inp2 = 32'd3;
      #1 chk("alu W5 instance sub", out5, 32'd7);

      // ---- Randomized ALU against reference model
      for (int i = 0; i < 300; i++) begin
         opc  = 5'($urandom_range(0, 31));
         inp1 = $urandom();
         inp2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom();
         #1;
         chk($sformatf("alu rnd opc%0d a=%08h b=%08h", opc, inp1, inp2),
             out8, ref_alu(int'(opc), inp1, inp2));
      end

      // ---- Randomized memory traffic against reference arrays
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 256; k++) model8[k] = 32'd0;
      for (int k = 0; k < 32; k++)  model5[k] = 32'd0;
      for (int i = 0; i < 200; i++) begin
         we8 = 1'($urandom_range(0, 1)); adra8 = 8'($urandom_range(0, 255));
         din8 = $urandom();
         adrb8 = ($urandom_range(0, 2) == 0) ? adra8 : 8'($urandom_range(0, 255));
         we5 = 1'($urandom_range(0, 1)); adra5 = 5'($urandom_range(0, 31));
         din5 = $urandom();
         adrb5 = ($urandom_range(0, 2) == 0) ? adra5 : 5'($urandom_range(0, 31));
         #1;
         chk($sformatf("mem8 pre a%0d", adrb8), dout8, model8[adrb8]);
         chk($sformatf("mem5 pre a%0d", adrb5), dout5, model5[adrb5]);
         tick();
         if (we8) model8[adra8] = din8;
         if (we5) model5[adra5] = din5;
         chk($sformatf("mem8 post a%0d", adrb8), dout8, model8[adrb8]);
         chk($sformatf("mem5 post a%0d", adrb5), dout5, model5[adrb5]);
      end
      we8 = 1'b0; we5 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
